// File: rtl/cipher_uart_tx.sv
// Ciphertext byte sink for picoblaze_1: captures port writes into a FIFO and
// serialises them on an 8N1 UART line, exposing a pollable status byte.
module cipher_uart_tx #(
  parameter logic [7:0]  DATA_PORT_ID    = 8'h20,
  parameter logic [7:0]  CLEAR_PORT_ID   = 8'h21,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter int unsigned CLKS_PER_BIT    = 434
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               port_id,
  input  logic                     write_strobe,
  input  logic [7:0]               out_port,
  output logic [7:0]               status,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     txd
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned PtrW  = FIFO_DEPTH_LOG2;
  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, busy;
  logic            data_wr, clear_wr, push, pop;

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;

  assign full     = (count_q == (PtrW + 1)'(Depth));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  assign data_wr  = write_strobe && (port_id == DATA_PORT_ID);
  assign clear_wr = write_strobe && (port_id == CLEAR_PORT_ID);
  // Full is sampled before this cycle's pop, so a simultaneous pop never frees a slot.
  assign push     = data_wr && !full;

  // FIFO bookkeeping and sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (data_wr && full) overflow_d = 1'b1;
    if (clear_wr)        overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= out_port;
  end

  // TX next-state logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StData: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      StStop: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Line level decoded purely from registered state, so reset forces it high at once.
  always_comb begin
    txd = 1'b1;
    case (state_q)
      StStart: txd = 1'b0;
      StData:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign status     = {4'b0000, overflow_q, busy, empty, full};
  assign fifo_count = count_q;

endmodule
